// File: rtl/freq_meter.sv
// Gate-window frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Optional FREQ_METER_LIVE_EN adds live_count and gate_progress outputs.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow
`ifdef FREQ_METER_LIVE_EN
  ,
  output logic [CNT_W-1:0] live_count,
  output logic [7:0]       gate_progress
`endif
);

  localparam int unsigned      GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_d_q;
  logic                   edge_p;

  state_t                 state_q;
  logic [GW-1:0]          gate_cnt_q;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   sat_q, sat_d;
  logic                   busy_q, count_valid_q, overflow_q;
  logic [CNT_W-1:0]       count_out_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q     <= '0;
      synced_d_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      synced_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_p = sync_q[SYNC_STAGES-1] & ~synced_d_q;

  // Counter value including this cycle's edge, so the last gate cycle lands in the result.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    if (edge_p) begin
      if (&edge_cnt_q) sat_d = 1'b1;
      else             edge_cnt_d = edge_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= IDLE;
      gate_cnt_q    <= '0;
      edge_cnt_q    <= '0;
      sat_q         <= 1'b0;
      busy_q        <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      count_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start || cont) begin
            state_q    <= GATE;
            busy_q     <= 1'b1;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
          end
        end
        GATE: begin
          gate_cnt_q <= gate_cnt_q + GATE_ONE;
          edge_cnt_q <= edge_cnt_d;
          sat_q      <= sat_d;
          if (gate_cnt_q == GATE_LAST) begin
            state_q       <= DONE;
            busy_q        <= 1'b0;
            count_out_q   <= edge_cnt_d;
            overflow_q    <= sat_d;
            count_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (cont) begin
            state_q    <= GATE;
            busy_q     <= 1'b1;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;

`ifdef FREQ_METER_LIVE_EN
  logic [GW+7:0] prog_num;
  logic [GW+7:0] prog_quot;

  assign live_count    = edge_cnt_q;
  assign prog_num      = {gate_cnt_q, 8'h00};
  assign prog_quot     = prog_num / (GW + 8)'(GATE_CYCLES);
  assign gate_progress = (state_q == GATE) ? prog_quot[7:0] : '0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a 27-bit and a 4-bit instance share stimulus,
// expected results are queued when a measurement is launched and popped on count_valid.
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sig_in, start, cont;
  logic        busy_a, valid_a, ovf_a;
  logic [26:0] cnt_a;
  logic        busy_b, valid_b, ovf_b;
  logic [3:0]  cnt_b;

`ifdef FREQ_METER_LIVE_EN
  logic [26:0] live_a;
  logic [3:0]  live_b;
  logic [7:0]  prog_a, prog_b;
`endif

  freq_meter #(.GATE_CYCLES(100), .CNT_W(27), .SYNC_STAGES(2)) u_dut (
    .clk_in(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy_a), .count_out(cnt_a), .count_valid(valid_a), .overflow(ovf_a)
`ifdef FREQ_METER_LIVE_EN
    , .live_count(live_a), .gate_progress(prog_a)
`endif
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) u_sat (
    .clk_in(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy_b), .count_out(cnt_b), .count_valid(valid_b), .overflow(ovf_b)
`ifdef FREQ_METER_LIVE_EN
    , .live_count(live_b), .gate_progress(prog_b)
`endif
  );

  typedef struct {
    int unsigned cnt;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned period   = 0;
  int unsigned ph       = 0;
  int unsigned busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  function automatic int unsigned exp_count(input int unsigned p);
    return (p == 0) ? 0 : 100 / p;
  endfunction

  // Synchronous square wave of the current period (high for the first half).
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (period == 0) begin
        sig_in = 1'b0;
        ph     = 0;
      end else begin
        ph     = (ph + 1 >= period) ? 0 : ph + 1;
        sig_in = (ph < period / 2);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_a || valid_b) begin
      check("valid_align", valid_b, valid_a);
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e_mon = sb.pop_front();
        check("count_wide", cnt_a, e_mon.cnt);
        check("ovf_wide", ovf_a, 0);
        check("count_sat", cnt_b, (e_mon.cnt > 15) ? 15 : e_mon.cnt);
        check("ovf_sat", ovf_b, (e_mon.cnt > 15) ? 1 : 0);
        check("valid_cycle", cyc, e_mon.due);
        check("busy_len", busy_run, 100);
        check("busy_done_wide", busy_a, 0);
        check("busy_done_sat", busy_b, 0);
      end
      busy_run = 0;
    end else if (busy_a) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  task automatic set_period(input int unsigned p);
    period = p;
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_start(input bit expect_result);
    @(negedge clk);
    start = 1'b1;
    if (expect_result) sb.push_back('{cnt: exp_count(period), due: cyc + 101});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
    check("results_drained", sb.size(), 0);
    sb.delete();
    repeat (5) @(negedge clk);
  endtask

  task automatic check_zero_outputs();
    check("rst_busy", busy_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_busy_sat", busy_b, 0);
    check("rst_count_sat", cnt_b, 0);
    check("rst_ovf_sat", ovf_b, 0);
  endtask

  int unsigned m;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    repeat (4) @(negedge clk);
    check_zero_outputs();
    rst = 1'b0;

    // Single shots: period 10, held low, saturating period 4, then recovery.
    set_period(10);
    pulse_start(1'b1);
    drain();
    set_period(0);
    pulse_start(1'b1);
    drain();
    set_period(4);
    pulse_start(1'b1);
    drain();
    set_period(10);
    pulse_start(1'b1);
    drain();

    // Continuous mode, cont dropped in the middle of the third window.
    set_period(20);
    @(negedge clk);
    cont = 1'b1;
    m = cyc;
    for (int unsigned k = 0; k < 3; k++) sb.push_back('{cnt: 5, due: m + 101 + 101 * k});
    repeat (252) @(negedge clk);
    cont = 1'b0;
    drain();
    repeat (250) @(negedge clk);
    check("idle_after_cont", busy_a, 0);

    // Second start inside an open window is ignored.
    set_period(10);
    pulse_start(1'b1);
    repeat (49) @(negedge clk);
    pulse_start(1'b0);
    drain();
    repeat (150) @(negedge clk);
    check("idle_after_ignored", busy_a, 0);

    // Reset at cycle 60 of a window aborts it and clears the outputs.
    pulse_start(1'b0);
    repeat (59) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero_outputs();
    repeat (150) @(negedge clk);
    check("no_result_after_rst", cnt_a, 0);
    pulse_start(1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
